// File: rtl/la_ioring_seq_if.sv
// Control/status bundle between the always-on controller and the IO ring sequencer.
// The sequencer connects through the slave modport; the controller/padring side uses master.
interface la_ioring_seq_if #(
  parameter int NSEG  = 4,
  parameter int RINGW = 8,
  parameter int CNTW  = 8
);
  logic             on_req;
  logic             off_req;
  logic [CNTW-1:0]  dly;
  logic [NSEG-1:0]  pgood;
  logic [RINGW-1:0] ring_cfg;
  logic [NSEG-1:0]  seg_en;
  logic [NSEG-1:0]  seg_iso;
  logic [RINGW-1:0] ring_out;
  logic             busy;
  logic             on;
  logic             fault;

  modport master (
    output on_req, off_req, dly, pgood, ring_cfg,
    input  seg_en, seg_iso, ring_out, busy, on, fault
  );

  modport slave (
    input  on_req, off_req, dly, pgood, ring_cfg,
    output seg_en, seg_iso, ring_out, busy, on, fault
  );
endinterface

// File: rtl/la_ioring_seq.sv
// IO ring power sequencer: enables segments one at a time with a settle delay and
// power-good check, tears them down in reverse order, and traps power-good faults.
module la_ioring_seq #(
  parameter int NSEG  = 4,
  parameter int RINGW = 8,
  parameter int CNTW  = 8,
  parameter int TMO   = 255
) (
  input  logic          clk,
  input  logic          reset,
  la_ioring_seq_if.slave bus
);
  localparam int IDXW = $clog2(NSEG);
  localparam logic [IDXW-1:0] LAST  = IDXW'(NSEG - 1);
  localparam logic [CNTW-1:0] TMO_C = CNTW'(TMO);

  typedef enum logic [2:0] {S_OFF, S_PWRUP, S_ON, S_PWRDN, S_FAULT} state_t;

  state_t           r_state, w_state;
  logic [IDXW-1:0]  r_idx, w_idx;
  logic [CNTW-1:0]  r_cnt, w_cnt;
  logic [CNTW-1:0]  r_dly, w_dly;
  logic [NSEG-1:0]  r_seg_en, w_seg_en;
  logic [NSEG-1:0]  r_seg_iso, w_seg_iso;
  logic [RINGW-1:0] r_ring, w_ring;
  logic             r_busy, w_busy;
  logic             r_on, w_on;
  logic             r_fault, w_fault;
  logic             w_trip;

  // NOTE: every output is a register, so the FSM computes next values here and the
  // state process below only samples them; no output is decoded combinationally.
  always_comb begin
    // NOTE: all next values default to the current register value first, so no
    // path through the case statement can leave one unassigned and infer a latch.
    w_state   = r_state;
    w_idx     = r_idx;
    w_cnt     = r_cnt;
    w_dly     = r_dly;
    w_seg_en  = r_seg_en;
    w_seg_iso = r_seg_iso;
    w_ring    = r_ring;
    w_busy    = r_busy;
    w_on      = r_on;
    w_fault   = r_fault;
    w_trip    = 1'b0;

    unique case (r_state)
      S_OFF: begin
        if (!bus.off_req && bus.on_req) begin
          w_state     = S_PWRUP;
          w_dly       = bus.dly;
          w_idx       = '0;
          w_cnt       = '0;
          w_seg_en    = '0;
          w_seg_en[0] = 1'b1;
          w_busy      = 1'b1;
        end
      end

      S_PWRUP: begin
        w_cnt = (r_cnt == TMO_C) ? r_cnt : r_cnt + CNTW'(1);
        if (bus.off_req) begin
          // Abort keeps idx so teardown starts from the highest enabled segment.
          w_state = S_PWRDN;
          w_dly   = bus.dly;
          w_cnt   = '0;
        end else if (r_cnt >= r_dly && bus.pgood[r_idx]) begin
          w_cnt = '0;
          if (r_idx == LAST) begin
            w_state   = S_ON;
            w_seg_iso = '0;
            w_ring    = bus.ring_cfg;
            w_on      = 1'b1;
            w_busy    = 1'b0;
          end else begin
            w_idx           = r_idx + IDXW'(1);
            w_seg_en[w_idx] = 1'b1;
          end
        end else if (r_cnt == TMO_C && !bus.pgood[r_idx]) begin
          w_trip = 1'b1;
        end
      end

      S_ON: begin
        if (bus.pgood != '1) begin
          w_trip = 1'b1;
        end else if (bus.off_req) begin
          w_state   = S_PWRDN;
          w_seg_iso = '1;
          w_ring    = '0;
          w_on      = 1'b0;
          w_busy    = 1'b1;
          w_dly     = bus.dly;
          w_idx     = LAST;
          w_cnt     = '0;
        end
      end

      S_PWRDN: begin
        if (r_cnt == r_dly) begin
          w_seg_en[r_idx] = 1'b0;
          w_cnt           = '0;
          if (r_idx == '0) begin
            w_state = S_OFF;
            w_busy  = 1'b0;
          end else begin
            w_idx = r_idx - IDXW'(1);
          end
        end else begin
          w_cnt = r_cnt + CNTW'(1);
        end
      end

      S_FAULT: begin
        if (bus.off_req) begin
          w_state = S_OFF;
          w_fault = 1'b0;
          w_idx   = '0;
          w_cnt   = '0;
        end
      end

      default: w_state = S_OFF;
    endcase

    if (w_trip) begin
      w_state   = S_FAULT;
      w_seg_en  = '0;
      w_seg_iso = '1;
      w_ring    = '0;
      w_on      = 1'b0;
      w_busy    = 1'b0;
      w_fault   = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_OFF;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_dly     <= '0;
      r_seg_en  <= '0;
      r_seg_iso <= '1;
      r_ring    <= '0;
      r_busy    <= 1'b0;
      r_on      <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_idx     <= w_idx;
      r_cnt     <= w_cnt;
      r_dly     <= w_dly;
      r_seg_en  <= w_seg_en;
      r_seg_iso <= w_seg_iso;
      r_ring    <= w_ring;
      r_busy    <= w_busy;
      r_on      <= w_on;
      r_fault   <= w_fault;
    end
  end

  assign bus.seg_en   = r_seg_en;
  assign bus.seg_iso  = r_seg_iso;
  assign bus.ring_out = r_ring;
  assign bus.busy     = r_busy;
  assign bus.on       = r_on;
  assign bus.fault    = r_fault;
endmodule
